// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and forwarding control for a five-stage MIPS-style
// pipeline that also has a multi-cycle multiply/divide unit writing HI/LO.
//
// Ports
//   clk, reset             single rising-edge clock, async active-high reset
//   RsD, RtD               source registers of the instruction in Decode
//   RsE, RtE               source registers of the instruction in Execute
//   WriteRegE/M/W          destination register carried by each stage
//   RegWriteE/M/W          register-file write enable per stage
//   MemtoRegE, MemtoRegM   the instruction in E / M is a load
//   BranchD                branch in D (its operands are compared in D)
//   MulDivStartE           a mult/div in E issues this cycle
//   HiLoUseD               the instruction in D needs HI/LO or the mult/div unit
//   StallF, StallD         hold the PC and the IF/ID register
//   FlushE                 bubble into ID/EX
//   ForwardAD, ForwardBD   D-stage comparator takes the M-stage result
//   ForwardAE, ForwardBE   ALU operand select: 00 regfile, 01 W, 10 M
//   MulDivBusy             a HI/LO result is still pending
//   StallCount             saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        MulDivStartE,
    input  logic        HiLoUseD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MulDivBusy,
    output logic [31:0] StallCount
);

    localparam logic [5:0]  MD_LOAD = 6'(MULDIV_CYCLES);
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    logic [5:0]  md_count;
    logic [31:0] stall_count_q;
    logic        lw_stall;
    logic        branch_stall;
    logic        md_stall;
    logic        stall;

    // Register $0 is hardwired to zero, so a "match" on it is never a real
    // dependency; every comparison in this block goes through this helper.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // ALU operand forwarding. The M stage holds the younger result, so it
    // wins over W when both write the same register.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && reg_match(RsE, WriteRegM)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && reg_match(RsE, WriteRegW)) begin
            ForwardAE = 2'b01;
        end

        ForwardBE = 2'b00;
        if (RegWriteM && reg_match(RtE, WriteRegM)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && reg_match(RtE, WriteRegW)) begin
            ForwardBE = 2'b01;
        end
    end

    // Branch operands are compared in D; only an M-stage ALU result can be
    // forwarded that early. Anything younger (E) or a load in M stalls instead.
    always_comb begin
        ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
        ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);
    end

    // Stall causes are ORed into one stall, so several simultaneous causes
    // still cost a single cycle and a single count increment.
    always_comb begin
        lw_stall     = MemtoRegE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE));
        branch_stall = BranchD &&
                       ((RegWriteE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE))) ||
                        (MemtoRegM && (reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM))));
        md_stall     = HiLoUseD && MulDivBusy;
        stall        = lw_stall || branch_stall || md_stall;
        StallF       = stall;
        StallD       = stall;
        FlushE       = stall;
    end

    // Mult/div occupancy counter. A new start always reloads, even while a
    // previous operation is still counting down, because the new operation
    // owns HI/LO from that point on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_count <= 6'd0;
        end else if (MulDivStartE) begin
            md_count <= MD_LOAD;
        end else if (md_count != 6'd0) begin
            md_count <= md_count - 6'd1;
        end
    end

    // Busy comes straight from the register, so it clears the moment reset
    // clears the counter and never depends on this cycle's inputs.
    assign MulDivBusy = (md_count != 6'd0);

    // Performance counter of stalled cycles; it sticks at all-ones rather
    // than wrapping so a long run never reports a misleadingly small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else if (stall && (stall_count_q != COUNT_MAX)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed self-checking bench for hazard_unit with MULDIV_CYCLES = 8.
// Inputs are driven with blocking assignments shortly after a rising edge
// and outputs are sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  RsD, RtD, RsE, RtE;
    logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemtoRegM;
    logic        BranchD, MulDivStartE, HiLoUseD;
    logic        StallF, StallD, FlushE;
    logic        ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MulDivBusy;
    logic [31:0] StallCount;

    int testsRun = 0;
    int testsFailed = 0;

    hazard_unit #(.MULDIV_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .RsD          (RsD),
        .RtD          (RtD),
        .RsE          (RsE),
        .RtE          (RtE),
        .WriteRegE    (WriteRegE),
        .WriteRegM    (WriteRegM),
        .WriteRegW    (WriteRegW),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .MemtoRegM    (MemtoRegM),
        .BranchD      (BranchD),
        .MulDivStartE (MulDivStartE),
        .HiLoUseD     (HiLoUseD),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushE       (FlushE),
        .ForwardAD    (ForwardAD),
        .ForwardBD    (ForwardBD),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .MulDivBusy   (MulDivBusy),
        .StallCount   (StallCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Returns every input to an idle, hazard-free value.
    task automatic clearInputs();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; MulDivStartE = 1'b0; HiLoUseD = 1'b0;
    endtask

    // Advances n rising edges and settles 1 unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Checks the three stall outputs together against one expected value.
    task automatic checkStall(input string tag, input logic expected);
        checkOutput({tag, ".StallF"}, {31'd0, StallF}, {31'd0, expected});
        checkOutput({tag, ".StallD"}, {31'd0, StallD}, {31'd0, expected});
        checkOutput({tag, ".FlushE"}, {31'd0, FlushE}, {31'd0, expected});
    endtask

    // Watchdog so the bench always finishes.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCycles;

        clearInputs();
        reset = 1'b1;
        #2;
        // Reset state, and combinational paths still live under reset.
        checkOutput("reset.MulDivBusy", {31'd0, MulDivBusy}, 32'd0);
        checkOutput("reset.StallCount", StallCount, 32'd0);
        MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        #1;
        checkStall("reset.comb", 1'b1);
        clearInputs();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1);

        // Load-use on RsD, then on RtD, then the $0 case.
        MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        #1;
        checkStall("lw.rs", 1'b1);
        RsD = 5'd3; RtD = 5'd8;
        #1;
        checkStall("lw.rt", 1'b1);
        WriteRegE = 5'd0; RsD = 5'd0; RtD = 5'd4;
        #1;
        checkStall("lw.zero", 1'b0);
        clearInputs();

        // Forwarding priority M over W, then W alone, then none.
        RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd5; WriteRegW = 5'd5; RsE = 5'd5;
        #1;
        checkOutput("fwd.AE_M", {30'd0, ForwardAE}, 32'd2);
        RegWriteM = 1'b0;
        #1;
        checkOutput("fwd.AE_W", {30'd0, ForwardAE}, 32'd1);
        RegWriteW = 1'b0;
        #1;
        checkOutput("fwd.AE_none", {30'd0, ForwardAE}, 32'd0);
        RegWriteM = 1'b1; WriteRegM = 5'd0; RtE = 5'd0;
        #1;
        checkOutput("fwd.BE_zero", {30'd0, ForwardBE}, 32'd0);
        RegWriteW = 1'b1; WriteRegW = 5'd7; RtE = 5'd7;
        #1;
        checkOutput("fwd.BE_W", {30'd0, ForwardBE}, 32'd1);
        WriteRegM = 5'd7;
        #1;
        checkOutput("fwd.BE_M", {30'd0, ForwardBE}, 32'd2);
        clearInputs();

        // Branch hazards: ALU result in E, load in M, then plain ALU in M.
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        #1;
        checkStall("br.E", 1'b1);
        RegWriteE = 1'b0; WriteRegE = 5'd0;
        MemtoRegM = 1'b1; WriteRegM = 5'd9;
        #1;
        checkStall("br.lwM", 1'b1);
        MemtoRegM = 1'b0; RegWriteM = 1'b1; RsD = 5'd9;
        #1;
        checkStall("br.aluM", 1'b0);
        checkOutput("br.ForwardBD", {31'd0, ForwardBD}, 32'd1);
        checkOutput("br.ForwardAD", {31'd0, ForwardAD}, 32'd1);
        clearInputs();

        // Mult/div: fresh counters, one-cycle start, then HI/LO use held.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        MulDivStartE = 1'b1;
        applyStimulus(1);
        MulDivStartE = 1'b0;
        HiLoUseD = 1'b1;
        #1;
        checkOutput("md.busy_first", {31'd0, MulDivBusy}, 32'd1);
        // Forwarding stays valid during the stall.
        RegWriteM = 1'b1; WriteRegM = 5'd12; RsE = 5'd12;
        #1;
        checkOutput("md.fwd_in_stall", {30'd0, ForwardAE}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("md.stall_%0d", i), {31'd0, StallF}, 32'd1);
            applyStimulus(1);
        end
        checkStall("md.release", 1'b0);
        checkOutput("md.busy_done", {31'd0, MulDivBusy}, 32'd0);
        checkOutput("md.count", StallCount, 32'd8);
        applyStimulus(1);
        checkOutput("md.count_hold", StallCount, 32'd8);
        clearInputs();

        // Restart with counter at 3 reloads to a full 8 cycles of busy.
        MulDivStartE = 1'b1;
        applyStimulus(1);
        MulDivStartE = 1'b0;
        applyStimulus(5);
        checkOutput("rst.busy_at3", {31'd0, MulDivBusy}, 32'd1);
        MulDivStartE = 1'b1;
        applyStimulus(1);
        MulDivStartE = 1'b0;
        busyCycles = 0;
        while (MulDivBusy && busyCycles < 20) begin
            busyCycles++;
            applyStimulus(1);
        end
        checkOutput("restart.busy_cycles", busyCycles, 32'd8);

        // Reset mid-count clears busy and the stall count between edges.
        MulDivStartE = 1'b1;
        applyStimulus(1);
        MulDivStartE = 1'b0;
        HiLoUseD = 1'b1;
        applyStimulus(2);
        checkOutput("midrst.count_before", StallCount, 32'd10);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst.busy", {31'd0, MulDivBusy}, 32'd0);
        checkOutput("midrst.count", StallCount, 32'd0);
        checkStall("midrst.stall", 1'b0);
        #1;
        reset = 1'b0;
        HiLoUseD = 1'b0;
        MulDivStartE = 1'b1;
        // First edge after reset is a normal cycle and accepts the start.
        applyStimulus(1);
        checkOutput("postrst.busy", {31'd0, MulDivBusy}, 32'd1);
        MulDivStartE = 1'b0;
        applyStimulus(10);
        clearInputs();

        // Saturation: preload near the top, then stall three cycles.
        @(negedge clk);
        force dut.stall_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_count_q;
        #1;
        checkOutput("sat.preload", StallCount, 32'hFFFF_FFFE);
        MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        applyStimulus(3);
        checkOutput("sat.top", StallCount, 32'hFFFF_FFFF);
        applyStimulus(1);
        checkOutput("sat.hold", StallCount, 32'hFFFF_FFFF);
        clearInputs();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
